float_class_counter: RTL and testbench
======================================

Name: float_class_counter

Overview:
- Pipeline stage directly downstream of the float classifier. Accepts a 32-bit IEEE-754 single value plus its 5-bit one-hot class vector over a valid/ready handshake.
- Registers both into a one-deep output stage with its own valid/ready handshake.
- Keeps saturating per-class, total and negative-sign counters, readable through a select port.
- Used by the FP test datapath to pass values onward and gather class statistics.

Parameters:
- CNT_W, 16, width of every statistics counter.

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream value valid
- in_ready  output  1  stage can accept this cycle
- num  input  32  IEEE-754 single value
- float_type  input  5  one-hot class: bit0 zero, bit1 normal, bit2 subnormal, bit3 infinity, bit4 NaN
- out_valid  output  1  output register holds a value
- out_ready  input  1  downstream accepts this cycle
- out_num  output  32  registered value
- out_type  output  5  registered class vector, passed through unmodified
- clr  input  1  synchronous clear of counters and err
- sel  input  3  counter select: 0–4 class bit index, 5 total, 6 negative, 7 reads 0
- count  output  CNT_W  selected counter, combinational mux of counter registers
- err  output  1  sticky flag: a non-one-hot class vector was accepted

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_num=0, out_type=0, all counters=0, err=0.
- Reset mid-transfer discards the held value. There is no replay.
- Accept: acc = in_valid && in_ready, where in_ready = !out_valid || out_ready (combinational; full throughput).
- Output stage:
  - On acc: out_num<=num, out_type<=float_type, out_valid<=1. Latency is 1 cycle.
  - Else if out_valid && out_ready: out_valid<=0; out_num and out_type hold their last values.
  - Otherwise hold.
- Output stability: while out_valid=1 and out_ready=0, out_num and out_type stay stable and in_ready=0.
- Simultaneous drain and accept (out_valid=1, out_ready=1, in_valid=1): the new value replaces the old and out_valid stays 1.
- Counting on acc, with clr=0:
  - Class check uses $onehot-equivalent logic on float_type.
  - If float_type is one-hot: increment cnt[i] for the set bit i.
  - If float_type is not one-hot (0 or ≥2 bits set): no class counter changes and err<=1.
  - total increments on every accept, including non-one-hot accepts.
  - neg increments when num[31]=1, independent of class.
- Saturation: every counter stops at 2^CNT_W-1 and never wraps.
- clr=1: all counters<=0 and err<=0. clr has priority over a same-cycle accept.
  - The accepted value is still registered to the output.
  - The accepted value is not counted.
- clr does not affect out_valid, out_num or out_type.
- count reflects register state. An accept or clr becomes visible on count the cycle after the clock edge.
- No other states. Behaviour is a one-entry buffer plus counters.

Test Plan:
- Reset, then stream 0x00000000, 0x3F800000, 0x00000001, 0x7F800000, 0x7FC00000, 0x80000000 with matching class vectors, out_ready=1.
  - Each value appears on out_num one cycle after acceptance.
  - sel 0..6 reads 2, 1, 1, 1, 1, 6, 1. err=0.
- Backpressure: hold out_ready=0 after the first accept, keep in_valid=1.
  - in_ready=0 and out_num stays stable for 5 cycles.
  - On out_ready=1, the next value loads in the same cycle. total counts each value exactly once.
- Accept 0x3F800000 with float_type=5'b00011, then one with 5'b00000.
  - err=1, cnt[0]=cnt[1]=0, total=2.
  - clr next cycle → err=0, all counts 0.
- clr asserted in the same cycle as an accept of 0x7F800000:
  - out_num=0x7F800000 and out_valid=1.
  - cnt[3]=0, total=0.
- CNT_W=4: accept 20 normals.
  - cnt[1] and total stay at 15. No wrap.
- Assert rst_n low mid-stream with out_valid=1.
  - out_valid=0 and all counters 0 immediately, without a clock edge.
  - After release, the first accept behaves normally.

Source files
------------

// File: rtl/float_class_counter.sv
// One-entry valid/ready register stage for classified floats, with saturating
// per-class, total and negative-sign statistics readable through a select port.
module float_class_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      num,
   input  logic [4:0]       float_type,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_num,
   output logic [4:0]       out_type,
   input  logic             clr,
   input  logic [2:0]       sel,
   output logic [CNT_W-1:0] count,
   output logic             err
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic             acc;
   logic             type_onehot;
   logic [4:0]       type_m1;
   logic [CNT_W-1:0] cls_cnt [5];
   logic [CNT_W-1:0] total_cnt;
   logic [CNT_W-1:0] neg_cnt;

   assign in_ready = !out_valid || out_ready;
   assign acc      = in_valid && in_ready;

   // x & (x-1) clears the lowest set bit; zero result with x nonzero means one-hot
   assign type_m1     = float_type - 5'd1;
   assign type_onehot = (|float_type) && !(|(float_type & type_m1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_num   <= '0;
         out_type  <= '0;
      end else if (acc) begin
         out_valid <= 1'b1;
         out_num   <= num;
         out_type  <= float_type;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

   for (genvar g = 0; g < 5; g++) begin : g_cls
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cls_cnt[g] <= '0;
         end else if (clr) begin
            cls_cnt[g] <= '0;
         end else if (acc && type_onehot && float_type[g] && (cls_cnt[g] != '1)) begin
            cls_cnt[g] <= cls_cnt[g] + CNT_ONE;
         end
      end
   end

   // clr wins over a same-cycle accept: the value still moves to the output but is not counted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         total_cnt <= '0;
         neg_cnt   <= '0;
         err       <= 1'b0;
      end else if (clr) begin
         total_cnt <= '0;
         neg_cnt   <= '0;
         err       <= 1'b0;
      end else if (acc) begin
         if (total_cnt != '1) begin
            total_cnt <= total_cnt + CNT_ONE;
         end
         if (num[31] && (neg_cnt != '1)) begin
            neg_cnt <= neg_cnt + CNT_ONE;
         end
         if (!type_onehot) begin
            err <= 1'b1;
         end
      end
   end

   always_comb begin
      count = '0;
      case (sel)
         3'd0:    count = cls_cnt[0];
         3'd1:    count = cls_cnt[1];
         3'd2:    count = cls_cnt[2];
         3'd3:    count = cls_cnt[3];
         3'd4:    count = cls_cnt[4];
         3'd5:    count = total_cnt;
         3'd6:    count = neg_cnt;
         default: count = '0;
      endcase
   end

endmodule

// File: tb/tb_float_class_counter.sv
// Scoreboard bench for float_class_counter: stimulus pushes expected output
// beats, a negedge monitor pops them on each output handshake.
module tb_float_class_counter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] num = '0;
   logic [4:0]  float_type = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_num;
   logic [4:0]  out_type;
   logic        clr = 1'b0;
   logic [2:0]  sel = '0;
   logic [15:0] count;
   logic        err;

   logic        in4_valid = 1'b0;
   logic        in4_ready;
   logic        out4_valid;
   logic [31:0] out4_num;
   logic [4:0]  out4_type;
   logic [2:0]  sel4 = '0;
   logic [3:0]  count4;
   logic        err4;

   int unsigned n_chk = 0;
   int unsigned n_pass = 0;
   logic [36:0] sb [$];

   always #5 clk = ~clk;

   float_class_counter #(.CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .num(num), .float_type(float_type), .out_valid(out_valid),
      .out_ready(out_ready), .out_num(out_num), .out_type(out_type),
      .clr(clr), .sel(sel), .count(count), .err(err)
   );

   float_class_counter #(.CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in4_valid), .in_ready(in4_ready),
      .num(32'h3F80_0000), .float_type(5'b00010), .out_valid(out4_valid),
      .out_ready(1'b1), .out_num(out4_num), .out_type(out4_type),
      .clr(1'b0), .sel(sel4), .count(count4), .err(err4)
   );

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [2:0] s, input int unsigned exp, input string name);
      sel = s;
      #1;
      chk(name, count, exp);
   endtask

   task automatic send(input logic [31:0] n, input logic [4:0] t);
      int unsigned w = 0;
      num = n;
      float_type = t;
      in_valid = 1'b1;
      while (!in_ready && w < 100) begin
         step();
         w++;
      end
      if (!in_ready) begin
         chk("send_timeout", 0, 1);
      end else begin
         sb.push_back({t, n});
         step();
         chk("latency_num", out_num, n);
      end
      in_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      logic [36:0] e;
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_out", 0, 1);
         end else begin
            e = sb.pop_front();
            chk("sb_num", out_num, e[31:0]);
            chk("sb_type", out_type, e[36:32]);
         end
      end
   end

   initial begin
      // reset state
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_num", out_num, 0);
      chk("rst_err", err, 0);
      rd(3'd5, 0, "rst_total");
      rst_n = 1'b1;
      step();

      // basic stream, full throughput
      send(32'h0000_0000, 5'b00001);
      send(32'h3F80_0000, 5'b00010);
      send(32'h0000_0001, 5'b00100);
      send(32'h7F80_0000, 5'b01000);
      send(32'h7FC0_0000, 5'b10000);
      send(32'h8000_0000, 5'b00001);
      step();
      rd(3'd0, 2, "s1_zero");
      rd(3'd1, 1, "s1_normal");
      rd(3'd2, 1, "s1_sub");
      rd(3'd3, 1, "s1_inf");
      rd(3'd4, 1, "s1_nan");
      rd(3'd5, 6, "s1_total");
      rd(3'd6, 1, "s1_neg");
      rd(3'd7, 0, "s1_sel7");
      chk("s1_err", err, 0);

      // backpressure
      clr = 1'b1; step(); clr = 1'b0;
      out_ready = 1'b0;
      send(32'h4000_0000, 5'b00010);
      num = 32'h4040_0000; float_type = 5'b00010; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("bp_in_ready", in_ready, 0);
         chk("bp_hold_num", out_num, 32'h4000_0000);
         step();
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", in_ready, 1);
      send(32'h4040_0000, 5'b00010);
      chk("bp_out_valid", out_valid, 1);
      step();
      rd(3'd5, 2, "bp_total");
      rd(3'd1, 2, "bp_normal");

      // non-one-hot class vectors
      clr = 1'b1; step(); clr = 1'b0;
      send(32'h3F80_0000, 5'b00011);
      send(32'h3F80_0000, 5'b00000);
      chk("err_set", err, 1);
      rd(3'd0, 0, "err_cnt0");
      rd(3'd1, 0, "err_cnt1");
      rd(3'd5, 2, "err_total");
      clr = 1'b1; step(); clr = 1'b0;
      chk("clr_err", err, 0);
      for (int i = 0; i < 7; i++) rd(3'(i), 0, "clr_cnt");

      // clr coinciding with an accept
      send(32'h7F80_0000, 5'b01000);
      rd(3'd3, 1, "pre_clr_inf");
      clr = 1'b1;
      send(32'h7F80_0000, 5'b01000);
      clr = 1'b0;
      chk("clracc_valid", out_valid, 1);
      chk("clracc_num", out_num, 32'h7F80_0000);
      rd(3'd3, 0, "clracc_inf");
      rd(3'd5, 0, "clracc_total");
      step();

      // saturation at CNT_W=4
      in4_valid = 1'b1;
      repeat (15) step();
      in4_valid = 1'b0;
      sel4 = 3'd1; #1; chk("sat_cnt1_15", count4, 15);
      in4_valid = 1'b1;
      repeat (5) step();
      in4_valid = 1'b0;
      sel4 = 3'd1; #1; chk("sat_cnt1_hold", count4, 15);
      sel4 = 3'd5; #1; chk("sat_total_hold", count4, 15);

      // asynchronous reset with a held value
      out_ready = 1'b0;
      send(32'hC000_0000, 5'b00010);
      chk("pre_rst_valid", out_valid, 1);
      sel = 3'd5;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_num", out_num, 0);
      chk("arst_total", count, 0);
      sb.delete();
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      step();
      send(32'h3F80_0000, 5'b00010);
      step();
      rd(3'd1, 1, "post_rst_normal");
      rd(3'd5, 1, "post_rst_total");
      rd(3'd6, 0, "post_rst_neg");
      chk("sb_empty", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
